// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of FWFT FIFOs into one valid/ready stream, with a latched per-queue burst quota per grant.
// One arbitration cycle per grant, then one word per cycle; pops stall while the output register is held by !mst_ready.
module fifo_rr_scheduler #(
    parameter  int NR_OF_QUEUES_P = 4,
    parameter  int DATA_WIDTH_P   = 64,
    parameter  int BURST_WIDTH_P  = 4,
    localparam int QID_WIDTH_C    = $clog2(NR_OF_QUEUES_P)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_enable,
    input  logic [NR_OF_QUEUES_P*BURST_WIDTH_P-1:0] cfg_burst,
    input  logic [NR_OF_QUEUES_P-1:0]               fifo_empty,
    input  logic [NR_OF_QUEUES_P*DATA_WIDTH_P-1:0]  fifo_data,
    output logic [NR_OF_QUEUES_P-1:0]               fifo_pop,
    output logic                                    mst_valid,
    input  logic                                    mst_ready,
    output logic [DATA_WIDTH_P-1:0]                 mst_data,
    output logic [QID_WIDTH_C-1:0]                  mst_queue_id,
    output logic                                    sr_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [QID_WIDTH_C-1:0]   rr_ptr_q, rr_ptr_d;
    logic [QID_WIDTH_C-1:0]   grant_q, grant_d;
    logic [BURST_WIDTH_P-1:0] credit_q, credit_d;
    logic                     mst_valid_q, mst_valid_d;
    logic [DATA_WIDTH_P-1:0]  mst_data_q, mst_data_d;
    logic [QID_WIDTH_C-1:0]   mst_qid_q, mst_qid_d;

    logic [DATA_WIDTH_P-1:0]  data_arr  [NR_OF_QUEUES_P];
    logic [BURST_WIDTH_P-1:0] burst_arr [NR_OF_QUEUES_P];

    for (genvar i = 0; i < NR_OF_QUEUES_P; i++) begin : g_unpack
        assign data_arr[i]  = fifo_data[i*DATA_WIDTH_P +: DATA_WIDTH_P];
        assign burst_arr[i] = cfg_burst[i*BURST_WIDTH_P +: BURST_WIDTH_P];
    end

    logic [QID_WIDTH_C-1:0]   sel;
    logic                     sel_vld;
    logic [QID_WIDTH_C:0]     idx;
    logic [BURST_WIDTH_P-1:0] quota;
    logic                     pop;

    // First non-empty queue after rr_ptr_q, wrapping modulo the queue count
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NR_OF_QUEUES_P; k++) begin
            idx = {1'b0, rr_ptr_q} + (QID_WIDTH_C+1)'(k);
            if (idx >= (QID_WIDTH_C+1)'(NR_OF_QUEUES_P)) begin
                idx = idx - (QID_WIDTH_C+1)'(NR_OF_QUEUES_P);
            end
            if (!sel_vld && !fifo_empty[idx[QID_WIDTH_C-1:0]]) begin
                sel     = idx[QID_WIDTH_C-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        credit_d    = credit_q;
        mst_valid_d = mst_valid_q;
        mst_data_d  = mst_data_q;
        mst_qid_d   = mst_qid_q;
        pop         = 1'b0;
        fifo_pop    = '0;
        quota       = (burst_arr[sel] == '0) ? BURST_WIDTH_P'(1) : burst_arr[sel];

        case (state_q)
            IDLE: begin
                if (cfg_enable && sel_vld) begin
                    grant_d  = sel;
                    credit_d = quota;
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                pop                = !fifo_empty[grant_q] && (!mst_valid_q || mst_ready);
                fifo_pop[grant_q]  = pop;
                // Empty flag is registered upstream, so a drained queue is only seen here one cycle late
                if (fifo_empty[grant_q] || (pop && credit_q == BURST_WIDTH_P'(1))) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
                if (pop) begin
                    credit_d = credit_q - BURST_WIDTH_P'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            mst_valid_d = 1'b1;
            mst_data_d  = data_arr[grant_q];
            mst_qid_d   = grant_q;
        end else if (mst_valid_q && mst_ready) begin
            mst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= QID_WIDTH_C'(NR_OF_QUEUES_P - 1);
            grant_q     <= '0;
            credit_q    <= '0;
            mst_valid_q <= 1'b0;
            mst_data_q  <= '0;
            mst_qid_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            credit_q    <= credit_d;
            mst_valid_q <= mst_valid_d;
            mst_data_q  <= mst_data_d;
            mst_qid_q   <= mst_qid_d;
        end
    end

    assign mst_valid    = mst_valid_q;
    assign mst_data     = mst_data_q;
    assign mst_queue_id = mst_qid_q;
    assign sr_busy      = (state_q == SERVE) || mst_valid_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: FWFT FIFO environment, queue-level reference model, directed and random phases.
module tb_fifo_rr_scheduler;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int BW = 4;
    localparam int QW = 2;

    logic            clk;
    logic            rst_n;
    logic            cfg_enable;
    logic [N*BW-1:0] cfg_burst;
    logic [N-1:0]    fifo_empty;
    logic [N*DW-1:0] fifo_data;
    logic [N-1:0]    fifo_pop;
    logic            mst_valid;
    logic            mst_ready;
    logic [DW-1:0]   mst_data;
    logic [QW-1:0]   mst_queue_id;
    logic            sr_busy;

    fifo_rr_scheduler #(
        .NR_OF_QUEUES_P(N),
        .DATA_WIDTH_P  (DW),
        .BURST_WIDTH_P (BW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_enable   (cfg_enable),
        .cfg_burst    (cfg_burst),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_pop     (fifo_pop),
        .mst_valid    (mst_valid),
        .mst_ready    (mst_ready),
        .mst_data     (mst_data),
        .mst_queue_id (mst_queue_id),
        .sr_busy      (sr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO contents, plus words to be written at the next clock edge
    logic [DW-1:0] fq   [N][$];
    logic [DW-1:0] pend [N][$];
    logic [N-1:0]  last_pop;
    logic          nx_ready;
    logic          nx_enable;
    logic [BW-1:0] nx_burst  [N];
    logic [BW-1:0] cur_burst [N];

    // Reference model: which queue is being served, how many words it may still give, output word
    bit            m_busy;
    int            m_grant;
    int            m_left;
    int            m_ptr;
    bit            m_vld;
    logic [DW-1:0] m_dat;
    int            m_qid;

    int            n_cmp;
    int            n_bad;
    int            cyc;
    int            acc_cyc [$];
    int            acc_q   [$];
    logic [DW-1:0] acc_d   [$];
    logic [N-1:0]  pop_log [$];
    int            pop_cyc [$];
    int            stall_pop;
    int            hold_chg;
    int            n_hold;
    bit            prev_hold;
    logic [DW-1:0] prev_data;

    task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = 0;
        m_left  = 0;
        m_ptr   = N - 1;
        m_vld   = 1'b0;
        m_dat   = '0;
        m_qid   = 0;
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        acc_q.delete();
        acc_d.delete();
        pop_log.delete();
        pop_cyc.delete();
        stall_pop = 0;
        hold_chg  = 0;
        n_hold    = 0;
        prev_hold = 1'b0;
    endtask

    function automatic bit all_empty();
        for (int q = 0; q < N; q++) begin
            if (fq[q].size() != 0 || pend[q].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Just after the rising edge: retire the popped word, write new words, apply new inputs
    task automatic edge_update();
        @(posedge clk);
        #1;
        for (int q = 0; q < N; q++) begin
            if (last_pop[q] && fq[q].size() > 0) void'(fq[q].pop_front());
            while (pend[q].size() > 0) fq[q].push_back(pend[q].pop_front());
            fifo_empty[q] = (fq[q].size() == 0);
            fifo_data[q*DW +: DW] = (fq[q].size() > 0) ? fq[q][0] : {$urandom, $urandom};
            cfg_burst[q*BW +: BW] = nx_burst[q];
            cur_burst[q] = nx_burst[q];
        end
        mst_ready  = nx_ready;
        cfg_enable = nx_enable;
    endtask

    // On the falling edge: compare against the model, log, then advance the model one cycle
    task automatic sample_step();
        logic [N-1:0] e_pop;
        logic [127:0] a;
        logic [127:0] e;
        bit           any;
        bit           found;
        bit           popped;
        int           q;
        @(negedge clk);
        cyc++;
        e_pop = '0;
        if (m_busy && fq[m_grant].size() > 0 && (!m_vld || mst_ready)) e_pop[m_grant] = 1'b1;
        a = 128'({fifo_pop, mst_valid, mst_queue_id, mst_data, sr_busy});
        e = 128'({e_pop, m_vld, 2'(m_qid), m_dat, m_busy || m_vld});
        chk_v($sformatf("cycle %0d {pop,valid,qid,data,busy}", cyc), a, e);

        if (mst_valid && mst_ready) begin
            acc_cyc.push_back(cyc);
            acc_q.push_back(int'(mst_queue_id));
            acc_d.push_back(mst_data);
        end
        if (fifo_pop != '0) begin
            pop_log.push_back(fifo_pop);
            pop_cyc.push_back(cyc);
        end
        if (mst_valid && !mst_ready) begin
            n_hold++;
            if (fifo_pop != '0) stall_pop++;
        end
        if (prev_hold && mst_data != prev_data) hold_chg++;
        prev_hold = mst_valid && !mst_ready;
        prev_data = mst_data;
        last_pop  = fifo_pop;

        popped = (e_pop != '0);
        if (popped) begin
            m_dat = fq[m_grant][0];
            m_qid = m_grant;
            m_vld = 1'b1;
        end else if (m_vld && mst_ready) begin
            m_vld = 1'b0;
        end
        if (!m_busy) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) if (fq[k].size() > 0) any = 1'b1;
            if (cfg_enable && any) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    q = (m_ptr + k) % N;
                    if (!found && fq[q].size() > 0) begin
                        m_grant = q;
                        found   = 1'b1;
                    end
                end
                m_left = (cur_burst[m_grant] == '0) ? 1 : int'(cur_burst[m_grant]);
                m_busy = 1'b1;
            end
        end else begin
            if (popped) m_left--;
            if (fq[m_grant].size() == 0 || (popped && m_left == 0)) begin
                m_busy = 1'b0;
                m_ptr  = m_grant;
            end
        end
    endtask

    task automatic cycle();
        edge_update();
        sample_step();
    endtask

    task automatic drain(input string nm, input int budget, input bit slow_ready);
        int n;
        n = 0;
        nx_enable = 1'b1;
        while ((!all_empty() || m_busy || m_vld) && n < budget) begin
            nx_ready = slow_ready ? (n % 3 == 0) : 1'b1;
            cycle();
            n++;
        end
        chk_i({nm, " finished within budget"}, int'(n < budget), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        cfg_enable = 1'b0;
        mst_ready  = 1'b0;
        cfg_burst  = '0;
        fifo_empty = '1;
        fifo_data  = '0;
        nx_ready   = 1'b1;
        nx_enable  = 1'b0;
        for (int q = 0; q < N; q++) begin
            nx_burst[q]  = '0;
            cur_burst[q] = '0;
        end
        last_pop = '0;
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        model_reset();
        clear_logs();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("reset mst_valid", int'(mst_valid), 0);
        chk_i("reset sr_busy", int'(sr_busy), 0);
        chk_i("reset fifo_pop", int'(fifo_pop), 0);
        chk_i("reset mst_queue_id", int'(mst_queue_id), 0);
        chk_v("reset mst_data", 128'(mst_data), 128'(0));
        #2 rst_n = 1'b1;

        // All four queues, 4 words each, quota 2
        clear_logs();
        for (int q = 0; q < N; q++) begin
            nx_burst[q] = 4'd2;
            for (int k = 0; k < 4; k++) pend[q].push_back(64'(q * 16 + k));
        end
        drain("t1", 200, 1'b0);
        chk_i("t1 words delivered", acc_q.size(), 16);
        if (acc_q.size() == 16) begin
            for (int j = 0; j < 16; j++) begin
                chk_i($sformatf("t1 qid[%0d]", j), acc_q[j], (j / 2) % 4);
                chk_v($sformatf("t1 data[%0d]", j), 128'(acc_d[j]),
                      128'(((j / 2) % 4) * 16 + (j / 8) * 2 + j % 2));
            end
            for (int j = 0; j < 15; j++)
                chk_i($sformatf("t1 gap[%0d]", j), acc_cyc[j+1] - acc_cyc[j], (j % 2 == 0) ? 1 : 2);
        end

        // Single queue, quota 0 treated as 1
        clear_logs();
        for (int q = 0; q < N; q++) nx_burst[q] = '0;
        for (int k = 0; k < 3; k++) pend[2].push_back(64'(160 + k));
        drain("t2", 60, 1'b0);
        chk_i("t2 pops", pop_log.size(), 3);
        chk_i("t2 words delivered", acc_q.size(), 3);
        foreach (pop_log[j]) chk_i($sformatf("t2 pop vector[%0d]", j), int'(pop_log[j]), 4);
        if (acc_q.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk_i($sformatf("t2 qid[%0d]", j), acc_q[j], 2);
                chk_v($sformatf("t2 data[%0d]", j), 128'(acc_d[j]), 128'(160 + j));
            end
            for (int j = 0; j < 2; j++)
                chk_i($sformatf("t2 gap[%0d]", j), acc_cyc[j+1] - acc_cyc[j], 2);
        end

        // Backpressure with ready pattern 1,0,0
        clear_logs();
        nx_burst[1] = 4'd8;
        for (int k = 0; k < 5; k++) pend[1].push_back(64'(176 + k));
        drain("t3", 100, 1'b1);
        chk_i("t3 words delivered", acc_q.size(), 5);
        if (acc_d.size() == 5)
            for (int j = 0; j < 5; j++) chk_v($sformatf("t3 data[%0d]", j), 128'(acc_d[j]), 128'(176 + j));
        chk_i("t3 pops", pop_log.size(), 5);
        chk_i("t3 pops while held", stall_pop, 0);
        chk_i("t3 data changes while held", hold_chg, 0);
        chk_i("t3 stall cycles seen", int'(n_hold > 0), 1);

        // Pointer at 1 after serving queue 1; then queues 0 and 3 together
        clear_logs();
        for (int q = 0; q < N; q++) nx_burst[q] = 4'd1;
        pend[1].push_back(64'h11);
        drain("t4a", 40, 1'b0);
        clear_logs();
        pend[0].push_back(64'hC0);
        pend[3].push_back(64'hC3);
        drain("t4b", 40, 1'b0);
        chk_i("t4 words delivered", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk_i("t4 first qid", acc_q[0], 3);
            chk_i("t4 second qid", acc_q[1], 0);
        end

        // Enable dropped after the first pop of a quota-4 grant
        clear_logs();
        nx_burst[0] = 4'd4;
        nx_enable   = 1'b1;
        nx_ready    = 1'b1;
        for (int k = 0; k < 6; k++) pend[0].push_back(64'(208 + k));
        n = 0;
        while (pop_log.size() == 0 && n < 20) begin
            cycle();
            n++;
        end
        chk_i("t5 first pop seen", int'(pop_log.size() > 0), 1);
        nx_enable = 1'b0;
        repeat (15) cycle();
        chk_i("t5 pops", pop_log.size(), 4);
        chk_i("t5 words left in queue 0", fq[0].size(), 2);
        chk_i("t5 sr_busy after grant", int'(sr_busy), 0);
        if (pop_cyc.size() > 0) chk_i("t5 no late pop", int'(pop_cyc[pop_cyc.size()-1] < cyc - 8), 1);
        drain("t5", 60, 1'b0);

        // Random traffic; first 600 cycles feed one queue at a time
        clear_logs();
        for (int i = 0; i < 3000; i++) begin
            for (int q = 0; q < N; q++) begin
                if ((i >= 600 || q == i / 200 % N) && $urandom_range(0, 9) < 3 &&
                    fq[q].size() + pend[q].size() < 8)
                    pend[q].push_back({$urandom, $urandom});
            end
            nx_ready  = ($urandom_range(0, 9) < 7);
            nx_enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) nx_burst[$urandom_range(0, N - 1)] = BW'($urandom);
            cycle();
        end
        drain("random", 800, 1'b0);

        // Reset while a word is held in the output register
        clear_logs();
        for (int q = 0; q < N; q++) nx_burst[q] = 4'd2;
        for (int k = 0; k < 3; k++) begin
            pend[0].push_back(64'(224 + k));
            pend[1].push_back(64'(232 + k));
        end
        nx_enable = 1'b1;
        nx_ready  = 1'b0;
        n = 0;
        while (!m_vld && n < 20) begin
            cycle();
            n++;
        end
        edge_update();
        chk_i("t7 valid before reset", int'(mst_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_i("t7 valid in reset", int'(mst_valid), 0);
        chk_i("t7 busy in reset", int'(sr_busy), 0);
        chk_i("t7 pop in reset", int'(fifo_pop), 0);
        model_reset();
        sample_step();
        #2 rst_n = 1'b1;
        clear_logs();
        drain("t7", 100, 1'b0);
        chk_i("t7 words after reset", acc_q.size(), 5);
        if (pop_log.size() > 0) chk_i("t7 first pop after reset", int'(pop_log[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
